pattern_det_param: RTL and testbench
====================================

// Module: pattern_det_param
// PURPOSE
//   Parametrised serial pattern detector; successor to the fixed-pattern PATTERN_DET.
//   Samples one bit per qualified clock from a serial stream.
//   Compares the last PAT_W bits against a run-time loadable pattern and don't-care mask.
//   Pulses DETo on each match, with selectable overlapping or non-overlapping detection.
//   Keeps a saturating match counter for status readback.
// PARAMETERS
//   PAT_W    4        pattern length in bits (2..32)
//   CNT_W    8        match counter width
//   OVERLAP  1        1: overlapping matches allowed; 0: history restarts after each match
//   DEF_PAT  4'b1011  pattern loaded at reset (PAT_W bits)
// PORTS
//   CLK      in   1      clock, all state updates on rising edge
//   RST      in   1      synchronous reset, active-high
//   Din      in   1      serial data bit
//   DinVld   in   1      Din qualifier; Din sampled only when 1
//   PatLoad  in   1      load PatIn/MaskIn this cycle
//   PatIn    in   PAT_W  new pattern (bit PAT_W-1 = oldest bit)
//   MaskIn   in   PAT_W  compare mask; 1 = compare, 0 = don't care
//   CntClr   in   1      clear MatchCnt
//   DETo     out  1      one-cycle match pulse
//   MatchCnt out  CNT_W  number of matches, saturating
// BEHAVIOUR
//   Reset (RST=1 at edge): SR=0, fill=0, PAT=DEF_PAT, MASK=all ones, DETo=0, MatchCnt=0.
//   RST overrides all other inputs.
//   State:
//     SR[PAT_W-1:0] bit history.
//     fill: valid-bit count, saturates at PAT_W; width clog2(PAT_W+1).
//   Shift (DinVld=1, PatLoad=0): SR <= {SR[PAT_W-2:0], Din}; fill <= min(fill+1, PAT_W).
//   Match condition, evaluated on shifted value SRn:
//     fill+1 >= PAT_W AND ((SRn ^ PAT) & MASK) == 0.
//   On match:
//     DETo=1 in the cycle after the edge that sampled the completing bit.
//     Latency is 1 clock; DETo is registered.
//     OVERLAP=1: fill stays at PAT_W, so the next bit can complete another match.
//     OVERLAP=0: fill <= 0; SR still shifts, but PAT_W new bits are needed before the next match.
//   DETo=0 in any cycle not following a match; a single match never produces a multi-cycle pulse.
//   DinVld=0: SR and fill hold; DETo=0 next cycle.
//   PatLoad=1:
//     PAT <= PatIn, MASK <= MaskIn, fill <= 0, SR <= 0.
//     Din is ignored that cycle even if DinVld=1.
//     No match is reported that cycle.
//   MASK=0 (all don't care): a match fires whenever fill reaches PAT_W.
//   MatchCnt: +1 per match, holds at 2^CNT_W-1.
//     CntClr=1 forces 0.
//     CntClr and a match in the same cycle: result 0; clear wins, the match is still pulsed on DETo.
//   Reset mid-stream discards partial history; PAT_W fresh bits are required after reset.
// TESTING
//   1. Overlap: PAT_W=4, OVERLAP=1, DEF_PAT=1011, DinVld=1; Din=1,0,1,1,0,1,1
//      -> DETo high after bits 4 and 7; MatchCnt=2.
//   2. Non-overlap: OVERLAP=0, same stream
//      -> DETo only after bit 4; MatchCnt=1.
//      Then Din=0,1,1 -> no pulse.
//      Then 1,0,1,1 -> pulse.
//   3. Mask: PatLoad with PatIn=1001, MaskIn=1001; Din=1,1,1,1 -> pulse.
//      Then 0,0,0,0 -> no pulse.
//      Verify no pulse fires until 4 bits after the load.
//   4. Gaps/reset: Din=1,0,1 with DinVld toggling 1,0,1,0,1 -> state holds across gaps.
//      Then RST for 1 cycle, then Din=1 -> no pulse; DETo=0 and MatchCnt=0 after reset.
//   5. Saturation/clear: CNT_W=2, 5 matches -> MatchCnt=3.
//      CntClr coincident with a match -> DETo=1, MatchCnt=0.
//   6. Load vs data: PatLoad and DinVld=1 in the same cycle -> Din dropped, fill=0.
//      The next 4 bits are required before any match.

Source files
------------

// File: rtl/pattern_det_param_if.sv
// Serial pattern detector bus: stream input, pattern load, counter clear and match status.
// The master drives the stream and control; the detector (slave) returns the pulse and count.
interface pattern_det_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             din;
    logic             din_vld;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic [PAT_W-1:0] mask_in;
    logic             cnt_clr;
    logic             det;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din, din_vld, pat_load, pat_in, mask_in, cnt_clr,
        input  det, match_cnt
    );

    modport slave (
        input  din, din_vld, pat_load, pat_in, mask_in, cnt_clr,
        output det, match_cnt
    );
endinterface

// File: rtl/pattern_det_param.sv
// Parametrised serial pattern detector with run-time pattern/mask, optional overlap
// and a saturating match counter. Match pulse is registered (one clock latency).
module pattern_det_param #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter bit               OVERLAP = 1'b1,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011)
) (
    input  logic              clk,
    input  logic              rst,
    pattern_det_param_if.slave bus
);
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  sr_reg, sr_next;
    logic [PAT_W-1:0]  pat_reg, pat_next;
    logic [PAT_W-1:0]  mask_reg, mask_next;
    logic [FILL_W-1:0] fill_reg, fill_next;
    logic              det_reg, det_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [PAT_W-1:0]  shifted;
    logic [PAT_W-1:0]  bit_ok;
    logic              match;

    // Compare is done on the history including the incoming bit
    assign shifted = {sr_reg[PAT_W-2:0], bus.din};

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
            assign bit_ok[gi] = ~mask_reg[gi] | ~(shifted[gi] ^ pat_reg[gi]);
        end
    endgenerate

    always_comb begin
        sr_next   = sr_reg;
        pat_next  = pat_reg;
        mask_next = mask_reg;
        fill_next = fill_reg;
        cnt_next  = cnt_reg;
        match     = 1'b0;

        if (bus.pat_load) begin
            pat_next  = bus.pat_in;
            mask_next = bus.mask_in;
            sr_next   = '0;
            fill_next = '0;
        end else if (bus.din_vld) begin
            sr_next = shifted;
            match   = (fill_reg >= FILL_LAST) && (&bit_ok);
            // Non-overlapping mode needs a full fresh window after every hit
            if (match && !OVERLAP) begin
                fill_next = '0;
            end else if (fill_reg != FILL_FULL) begin
                fill_next = fill_reg + FILL_W'(1);
            end
        end

        det_next = match;

        if (bus.cnt_clr) begin
            cnt_next = '0;
        end else if (match && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg   <= '0;
            fill_reg <= '0;
            pat_reg  <= DEF_PAT;
            mask_reg <= '1;
            det_reg  <= 1'b0;
            cnt_reg  <= '0;
        end else begin
            sr_reg   <= sr_next;
            fill_reg <= fill_next;
            pat_reg  <= pat_next;
            mask_reg <= mask_next;
            det_reg  <= det_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign bus.det       = det_reg;
    assign bus.match_cnt = cnt_reg;
endmodule

// File: tb/tb_pattern_det_param.sv
// Scoreboard bench: three detectors (overlap, non-overlap, 2-bit counter) share one stream;
// a queue-based reference model predicts pulses and counts, a monitor compares every cycle.
module tb_pattern_det_param;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pattern_det_param_if #(.PAT_W(PW), .CNT_W(8)) if0 ();
    pattern_det_param_if #(.PAT_W(PW), .CNT_W(8)) if1 ();
    pattern_det_param_if #(.PAT_W(PW), .CNT_W(2)) if2 ();

    pattern_det_param #(.PAT_W(PW), .CNT_W(8), .OVERLAP(1'b1), .DEF_PAT(4'b1011))
        u_ovl (.clk(clk), .rst(rst), .bus(if0.slave));
    pattern_det_param #(.PAT_W(PW), .CNT_W(8), .OVERLAP(1'b0), .DEF_PAT(4'b1011))
        u_nov (.clk(clk), .rst(rst), .bus(if1.slave));
    pattern_det_param #(.PAT_W(PW), .CNT_W(2), .OVERLAP(1'b1), .DEF_PAT(4'b1011))
        u_sat (.clk(clk), .rst(rst), .bus(if2.slave));

    typedef struct {
        logic [2:0] det;
        int         cnt0;
        int         cnt1;
        int         cnt2;
    } exp_t;

    exp_t expq[$];

    // Reference model: valid bits since last reset/load, per-instance window start
    bit       stream[$];
    int       start[3];
    logic [3:0] m_pat;
    logic [3:0] m_mask;
    int       m_cnt[3];
    int       ovl[3]  = '{1, 0, 1};
    int       cmax[3] = '{255, 255, 3};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit window_hits(input int k);
        int n;
        n = stream.size();
        if (n - start[k] < PW) return 1'b0;
        for (int i = 0; i < PW; i++) begin
            if (m_mask[i] && (stream[n-1-i] != m_pat[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic cycle(input logic r, input logic d, input logic v, input logic pl,
                         input logic [3:0] pi, input logic [3:0] mi, input logic cc);
        exp_t       e;
        logic [2:0] hit;
        @(negedge clk);
        rst = r;
        if0.din = d; if0.din_vld = v; if0.pat_load = pl; if0.pat_in = pi; if0.mask_in = mi; if0.cnt_clr = cc;
        if1.din = d; if1.din_vld = v; if1.pat_load = pl; if1.pat_in = pi; if1.mask_in = mi; if1.cnt_clr = cc;
        if2.din = d; if2.din_vld = v; if2.pat_load = pl; if2.pat_in = pi; if2.mask_in = mi; if2.cnt_clr = cc;
        hit = '0;
        if (r) begin
            stream.delete();
            m_pat  = 4'b1011;
            m_mask = 4'hF;
            for (int k = 0; k < 3; k++) begin
                start[k] = 0;
                m_cnt[k] = 0;
            end
        end else begin
            if (pl) begin
                m_pat  = pi;
                m_mask = mi;
                stream.delete();
                for (int k = 0; k < 3; k++) start[k] = 0;
            end else if (v) begin
                stream.push_back(d);
                for (int k = 0; k < 3; k++) begin
                    hit[k] = window_hits(k);
                    if (hit[k] && ovl[k] == 0) start[k] = stream.size();
                end
            end
            for (int k = 0; k < 3; k++) begin
                if (cc) m_cnt[k] = 0;
                else if (hit[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
        end
        e.det  = hit;
        e.cnt0 = m_cnt[0];
        e.cnt1 = m_cnt[1];
        e.cnt2 = m_cnt[2];
        expq.push_back(e);
    endtask

    task automatic bit_in(input logic d);
        cycle(1'b0, d, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic bits_msb(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(v[i]);
    endtask

    // Monitor: each posedge consumes the prediction pushed for it
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("ovl det", {31'b0, if0.det}, {29'b0, 2'b0, e.det[0]});
                chk("nov det", {31'b0, if1.det}, {31'b0, e.det[1]});
                chk("sat det", {31'b0, if2.det}, {31'b0, e.det[2]});
                chk("ovl cnt", {24'b0, if0.match_cnt}, e.cnt0);
                chk("nov cnt", {24'b0, if1.match_cnt}, e.cnt1);
                chk("sat cnt", {30'b0, if2.match_cnt}, e.cnt2);
                if (e.det != 3'b000)
                    $display("[TB] %0t match det=%b cnt=%0d/%0d/%0d", $time, e.det, e.cnt0, e.cnt1, e.cnt2);
            end
        end
    end

    initial begin
        logic r, d, v, pl, cc;
        logic [3:0] pi, mi;

        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        do_reset();
        chk("reset det", {31'b0, if0.det}, 32'd0);
        chk("reset cnt", {24'b0, if0.match_cnt}, 32'd0);
        bits_msb(16'b1011011, 7);
        idle();
        chk("t1 ovl det", {31'b0, if0.det}, 32'd1);
        chk("t1 nov det", {31'b0, if1.det}, 32'd0);
        chk("t1 ovl cnt", {24'b0, if0.match_cnt}, 32'd2);
        chk("t1 nov cnt", {24'b0, if1.match_cnt}, 32'd1);
        bits_msb(16'b1011, 4);
        idle();
        chk("t2 nov det", {31'b0, if1.det}, 32'd1);
        chk("t2 nov cnt", {24'b0, if1.match_cnt}, 32'd2);

        // Masked pattern 1x x1
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 4'b1001, 1'b0);
        bits_msb(16'b111, 3);
        idle();
        chk("t3 early det", {31'b0, if0.det}, 32'd0);
        bit_in(1'b1);
        idle();
        chk("t3 mask det", {31'b0, if0.det}, 32'd1);
        bits_msb(16'b0000, 4);
        idle();
        chk("t3 zeros det", {31'b0, if0.det}, 32'd0);

        // Gaps hold state; reset discards history
        do_reset();
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        bit_in(1'b1);
        idle();
        chk("t4 gap det", {31'b0, if0.det}, 32'd1);
        do_reset();
        bit_in(1'b1);
        idle();
        chk("t4 rst det", {31'b0, if0.det}, 32'd0);
        chk("t4 rst cnt", {24'b0, if0.match_cnt}, 32'd0);

        // Saturation and clear coincident with a match
        do_reset();
        bits_msb(16'b1011, 4);
        for (int i = 0; i < 4; i++) bits_msb(16'b011, 3);
        idle();
        chk("t5 sat cnt", {30'b0, if2.match_cnt}, 32'd3);
        chk("t5 ovl cnt", {24'b0, if0.match_cnt}, 32'd5);
        bits_msb(16'b01, 2);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        idle();
        chk("t5 clr det", {31'b0, if0.det}, 32'd1);
        chk("t5 clr cnt", {24'b0, if0.match_cnt}, 32'd0);
        chk("t5 clr sat", {30'b0, if2.match_cnt}, 32'd0);

        // Load wins over data in the same cycle
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1111, 1'b0);
        bits_msb(16'b011, 3);
        idle();
        chk("t6 drop det", {31'b0, if0.det}, 32'd0);
        bits_msb(16'b1011, 4);
        idle();
        chk("t6 late det", {31'b0, if0.det}, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 199) == 0);
            pl = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 4) != 0);
            cc = ($urandom_range(0, 49) == 0);
            d  = 1'($urandom_range(0, 1));
            pi = 4'($urandom_range(0, 15));
            mi = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            cycle(r, d, v, pl, pi, mi, cc);
        end
        idle();
        idle();
        @(posedge clk);
        #2;
        chk("scoreboard drained", expq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
